// File: rtl/bram_write_if.sv
// Write-request handshake between the memory-side write path and bram_write.
interface bram_write_if;
  logic [20:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;

  modport master (output wr_addr, output wr_data, output wr_valid, input wr_ready);
  modport slave  (input wr_addr, input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/bram_write.sv
// Queues byte writes in a small FIFO and drains one per cycle into one of two
// interleaved BRAM banks selected by address bit 3.
module bram_write #(
  parameter int         DEPTH      = 4,
  parameter bit         CHECK_BANK = 1'b1,
  parameter logic [3:0] BANK_SEL   = 4'b0000
) (
  input  logic        clk_memory,
  input  logic        reset,
  bram_write_if.slave wr,
  output logic        idle,
  output logic [7:0]  drop_count,
  output logic [15:0] bram0_addr,
  output logic [7:0]  bram0_din,
  output logic        bram0_en,
  output logic [0:0]  bram0_we,
  input  logic [7:0]  bram0_dout,
  output logic        bram0_clk,
  output logic [15:0] bram1_addr,
  output logic [7:0]  bram1_din,
  output logic        bram1_en,
  output logic [0:0]  bram1_we,
  input  logic [7:0]  bram1_dout,
  output logic        bram1_clk
);
  localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [16:0]      addr_mem [DEPTH];
  logic [7:0]       data_mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;
  logic             in_range, handshake, push, pop;
  logic [16:0]      head_addr_p0;
  logic [7:0]       head_data_p0;
  logic             unused_dout;

  // Read data belongs to the companion reader; this side only writes.
  assign unused_dout = ^{bram0_dout, bram1_dout};

  assign bram0_clk = clk_memory;
  assign bram1_clk = clk_memory;

  assign in_range    = !CHECK_BANK || (wr.wr_addr[20:17] == BANK_SEL);
  assign wr.wr_ready = !reset && (count != FULL_CNT);
  assign handshake   = wr.wr_valid && wr.wr_ready;
  assign push        = handshake && in_range;
  assign pop         = (count != '0);

  assign head_addr_p0 = addr_mem[head];
  assign head_data_p0 = data_mem[head];

  // Stage p0: FIFO storage, written on accepted in-range requests
  always_ff @(posedge clk_memory) begin
    if (push) begin
      addr_mem[tail] <= wr.wr_addr[16:0];
      data_mem[tail] <= wr.wr_data;
    end
  end

  always_ff @(posedge clk_memory or posedge reset) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      drop_count <= 8'd0;
    end else begin
      if (push) tail <= tail + PTR_ONE;
      if (pop)  head <= head + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (handshake && !in_range) drop_count <= sat_inc8(drop_count);
    end
  end

  // Stage p1: registered BRAM port drive; addr/din hold when nothing drains
  always_ff @(posedge clk_memory or posedge reset) begin
    if (reset) begin
      bram0_en   <= 1'b0;
      bram1_en   <= 1'b0;
      bram0_addr <= 16'd0;
      bram1_addr <= 16'd0;
      bram0_din  <= 8'd0;
      bram1_din  <= 8'd0;
    end else begin
      bram0_en <= pop && !head_addr_p0[3];
      bram1_en <= pop &&  head_addr_p0[3];
      if (pop) begin
        bram0_addr <= {head_addr_p0[16:4], head_addr_p0[2:0]};
        bram1_addr <= {head_addr_p0[16:4], head_addr_p0[2:0]};
        bram0_din  <= head_data_p0;
        bram1_din  <= head_data_p0;
      end
    end
  end

  assign bram0_we = bram0_en;
  assign bram1_we = bram1_en;

  assign idle = (count == '0) && !bram0_en && !bram1_en;
endmodule

// File: tb/tb_bram_write.sv
// Scoreboard bench for bram_write: stimulus pushes expected BRAM writes, a
// negedge monitor pops and compares whenever a bank enable is seen.
`timescale 1ns/1ps
module tb_bram_write;
  logic clk_memory = 1'b0;
  logic reset;
  always #5 clk_memory = ~clk_memory;

  bram_write_if wr_if();

  logic        idle;
  logic [7:0]  drop_count;
  logic [15:0] bram0_addr, bram1_addr;
  logic [7:0]  bram0_din, bram1_din;
  logic        bram0_en, bram1_en;
  logic [0:0]  bram0_we, bram1_we;
  logic        bram0_clk, bram1_clk;
  logic [7:0]  bram0_dout = 8'h00;
  logic [7:0]  bram1_dout = 8'h00;

  bram_write dut (
    .clk_memory (clk_memory),
    .reset      (reset),
    .wr         (wr_if.slave),
    .idle       (idle),
    .drop_count (drop_count),
    .bram0_addr (bram0_addr),
    .bram0_din  (bram0_din),
    .bram0_en   (bram0_en),
    .bram0_we   (bram0_we),
    .bram0_dout (bram0_dout),
    .bram0_clk  (bram0_clk),
    .bram1_addr (bram1_addr),
    .bram1_din  (bram1_din),
    .bram1_en   (bram1_en),
    .bram1_we   (bram1_we),
    .bram1_dout (bram1_dout),
    .bram1_clk  (bram1_clk)
  );

  typedef struct packed {
    logic        bank;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  bit   ready_low_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every enabled BRAM write must match the oldest expected entry
  always @(negedge clk_memory) begin
    if (!reset && (bram0_en || bram1_en)) begin
      if (sb.size() == 0) begin
        check("sb_spurious_write", {bram1_en, bram0_en}, 2'b00);
      end else begin
        mon_e = sb.pop_front();
        check("sb_bank_en_we", {bram1_en, bram0_en, bram1_we, bram0_we},
              mon_e.bank ? 4'b1010 : 4'b0101);
        check("sb_addr0", bram0_addr, mon_e.addr);
        check("sb_addr1", bram1_addr, mon_e.addr);
        check("sb_din0", bram0_din, mon_e.data);
        check("sb_din1", bram1_din, mon_e.data);
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic do_write(input logic [20:0] a, input logic [7:0] d);
    bit acc;
    acc = 1'b0;
    wr_if.wr_addr  = a;
    wr_if.wr_data  = d;
    wr_if.wr_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk_memory);
      if (!wr_if.wr_ready) ready_low_seen = 1'b1;
      acc = wr_if.wr_ready;
      @(posedge clk_memory);
      #1;
    end
    if (!acc) check("wr_accept_timeout", 32'd0, 32'd1);
    else if (a[20:17] == 4'b0000) sb.push_back('{bank: a[3], addr: {a[16:4], a[2:0]}, data: d});
  endtask

  task automatic idle_cycles(input int n);
    wr_if.wr_valid = 1'b0;
    repeat (n) @(posedge clk_memory);
    #1;
  endtask

  initial begin
    logic [16:0] r17;
    int run;
    int gap;
    reset          = 1'b1;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_addr  = '0;
    wr_if.wr_data  = '0;
    ready_low_seen = 1'b0;

    #1;
    check("rst_en", {bram1_en, bram0_en, bram1_we, bram0_we}, 4'b0000);
    check("rst_addr", {bram1_addr, bram0_addr}, 32'd0);
    check("rst_din", {bram1_din, bram0_din}, 16'd0);
    check("rst_drop", drop_count, 8'd0);
    check("rst_idle", idle, 1'b1);
    check("rst_ready", wr_if.wr_ready, 1'b0);

    repeat (3) @(posedge clk_memory);
    #2 reset = 1'b0;
    @(posedge clk_memory);
    #1;
    check("ready_after_rst", wr_if.wr_ready, 1'b1);

    // Single bank-0 write and its latency
    do_write(21'h00013, 8'hA5);
    wr_if.wr_valid = 1'b0;
    @(negedge clk_memory);
    check("t1_no_en_first_cycle", {bram1_en, bram0_en}, 2'b00);
    check("t1_busy", idle, 1'b0);
    @(negedge clk_memory);
    check("t1_bank0_en", {bram1_en, bram0_en}, 2'b01);
    check("t1_addr", bram0_addr, 16'h000B);
    check("t1_din", bram0_din, 8'hA5);
    @(negedge clk_memory);
    check("t1_en_off", {bram1_en, bram0_en}, 2'b00);
    check("t1_idle", idle, 1'b1);
    @(posedge clk_memory);
    #1;

    // Single bank-1 write
    do_write(21'h0001B, 8'h3C);
    wr_if.wr_valid = 1'b0;
    @(negedge clk_memory);
    @(negedge clk_memory);
    check("t2_bank1_en", {bram1_en, bram0_en}, 2'b10);
    check("t2_addr", bram1_addr, 16'h000B);
    check("t2_din", bram1_din, 8'h3C);
    idle_cycles(3);

    // Back-to-back stream, one write per cycle with no gaps
    ready_low_seen = 1'b0;
    run = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) do_write(21'(i), 8'(8'h10 + i));
        wr_if.wr_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 20 && !bram0_en; i++) @(negedge clk_memory);
        if (bram0_en) begin
          run = 1;
          repeat (7) begin
            @(negedge clk_memory);
            if (bram0_en) run++;
          end
        end
      end
    join
    check("t3_consecutive_writes", run, 8);
    check("t3_ready_never_low", ready_low_seen, 1'b0);
    idle_cycles(4);

    // Reset in the middle of a stream aborts the write in flight
    do_write(21'h00100, 8'h11);
    do_write(21'h00108, 8'h22);
    wr_if.wr_addr = 21'h00110;
    wr_if.wr_data = 8'h33;
    #1;
    check("t4_en_before_rst", bram0_en, 1'b1);
    reset = 1'b1;
    sb.delete();
    #1;
    check("t4_en_aborted", {bram1_en, bram0_en}, 2'b00);
    check("t4_idle_in_rst", idle, 1'b1);
    check("t4_ready_in_rst", wr_if.wr_ready, 1'b0);
    repeat (2) @(posedge clk_memory);
    wr_if.wr_valid = 1'b0;
    @(negedge clk_memory);
    reset = 1'b0;
    repeat (4) @(negedge clk_memory);
    check("t4_no_en_after_rst", {bram1_en, bram0_en}, 2'b00);
    check("t4_idle_after_rst", idle, 1'b1);
    @(posedge clk_memory);
    #1;
    do_write(21'h00118, 8'h44);
    do_write(21'h00120, 8'h55);
    do_write(21'h00128, 8'h66);
    idle_cycles(4);

    // Out-of-bank requests are dropped and counted, saturating at 255
    check("t5_drop_start", drop_count, 8'd0);
    do_write(21'h20010, 8'h77);
    idle_cycles(3);
    check("t5_drop_one", drop_count, 8'd1);
    check("t5_idle", idle, 1'b1);
    for (int i = 0; i < 299; i++) do_write(21'h20010, 8'(i));
    idle_cycles(3);
    check("t5_drop_saturated", drop_count, 8'd255);

    // Random in-bank stream with random valid gaps
    ready_low_seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      r17 = 17'($urandom);
      do_write({4'b0000, r17}, 8'($urandom));
      gap = $urandom_range(0, 3);
      if (gap != 0) idle_cycles(gap);
    end
    idle_cycles(6);
    check("t6_ready_never_low", ready_low_seen, 1'b0);
    check("t6_sb_drained", sb.size(), 0);
    check("t6_idle", idle, 1'b1);
    check("t6_drop_unchanged", drop_count, 8'd255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
